// File: rtl/button_events.sv
// Turns one debounced button level into one-cycle UI events: press, release,
// click, double click, long press and auto-repeat. All outputs are registered.
module button_events #(
    parameter int LONG_DELAY    = 50000000,
    parameter int REPEAT_PERIOD = 10000000,
    parameter int DOUBLE_WINDOW = 25000000
) (
    input  logic clock,
    input  logic reset,
    input  logic clean,
    output logic press_pulse,
    output logic release_pulse,
    output logic click_pulse,
    output logic double_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SHORT  = 3'd1,
        LONG   = 3'd2,
        GAP    = 3'd3,
        SECOND = 3'd4
    } state_t;

    localparam logic [31:0] LONG_LAST   = 32'(LONG_DELAY - 1);
    localparam logic [31:0] REPEAT_LAST = 32'(REPEAT_PERIOD - 1);
    localparam logic [31:0] WINDOW_END  = 32'(DOUBLE_WINDOW);

    state_t      state, state_next;
    logic [31:0] cnt, cnt_next;
    logic        prev;
    logic        rise;
    logic        press_next, release_next, click_next, double_next;
    logic        long_next, repeat_next, held_next;

    assign rise = clean & ~prev;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next   = state;
        cnt_next     = cnt;
        press_next   = 1'b0;
        release_next = 1'b0;
        click_next   = 1'b0;
        double_next  = 1'b0;
        long_next    = 1'b0;
        repeat_next  = 1'b0;

        case (state)
            IDLE: begin
                if (rise) begin
                    press_next = 1'b1;
                    state_next = SHORT;
                    cnt_next   = 32'd1;
                end
            end
            SHORT, SECOND: begin
                // A release after a first short press opens the double-click window.
                if (!clean) begin
                    release_next = 1'b1;
                    state_next   = (state == SHORT) ? GAP : IDLE;
                    cnt_next     = (state == SHORT) ? 32'd1 : 32'd0;
                end else if (cnt == LONG_LAST) begin
                    long_next  = 1'b1;
                    state_next = LONG;
                    cnt_next   = 32'd0;
                end else begin
                    cnt_next = cnt + 32'd1;
                end
            end
            LONG: begin
                if (!clean) begin
                    release_next = 1'b1;
                    state_next   = IDLE;
                    cnt_next     = 32'd0;
                end else if (cnt == REPEAT_LAST) begin
                    repeat_next = 1'b1;
                    cnt_next    = 32'd0;
                end else begin
                    cnt_next = cnt + 32'd1;
                end
            end
            GAP: begin
                // A rise on the last window edge still counts as a double click.
                if (rise) begin
                    press_next  = 1'b1;
                    double_next = 1'b1;
                    state_next  = SECOND;
                    cnt_next    = 32'd1;
                end else if (cnt == WINDOW_END) begin
                    click_next = 1'b1;
                    state_next = IDLE;
                    cnt_next   = 32'd0;
                end else begin
                    cnt_next = cnt + 32'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 32'd0;
            end
        endcase

        held_next = (state_next == SHORT) || (state_next == LONG) || (state_next == SECOND);
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state         <= IDLE;
            cnt           <= 32'd0;
            prev          <= clean;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            click_pulse   <= 1'b0;
            double_pulse  <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            prev          <= clean;
            press_pulse   <= press_next;
            release_pulse <= release_next;
            click_pulse   <= click_next;
            double_pulse  <= double_next;
            long_pulse    <= long_next;
            repeat_pulse  <= repeat_next;
            held          <= held_next;
        end
    end

endmodule

// File: tb/tb_button_events.sv
// Self-checking bench for button_events: directed scenarios plus randomized
// button activity against a timestamp-based event model.
module tb_button_events;

    localparam int LD = 10;
    localparam int RP = 4;
    localparam int DW = 6;

    localparam int PH_IDLE = 0;
    localparam int PH_HELD = 1;
    localparam int PH_GAP  = 2;

    logic clock, reset, clean;
    logic press_pulse, release_pulse, click_pulse, double_pulse;
    logic long_pulse, repeat_pulse, held;
    logic [6:0] outs;

    // Output vector order: press, release, click, double, long, repeat, held.
    assign outs = {press_pulse, release_pulse, click_pulse, double_pulse,
                   long_pulse, repeat_pulse, held};

    button_events #(
        .LONG_DELAY   (LD),
        .REPEAT_PERIOD(RP),
        .DOUBLE_WINDOW(DW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .clean        (clean),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .click_pulse  (click_pulse),
        .double_pulse (double_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse),
        .held         (held)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: tracks press/release timestamps and derives events from them.
    int         edge_t  = 0;
    int         phase   = PH_IDLE;
    int         press_t = 0;
    int         rel_t   = 0;
    bit         second  = 1'b0;
    logic       m_prev  = 1'b0;
    logic [6:0] exp_out = '0;

    task automatic model_edge(input logic c, input logic r);
        logic [6:0] e;
        int d;
        e = '0;
        if (r) begin
            phase = PH_IDLE;
        end else begin
            case (phase)
                PH_IDLE: begin
                    if (c && !m_prev) begin
                        e[6] = 1'b1;
                        phase = PH_HELD; press_t = edge_t; second = 1'b0;
                    end
                end
                PH_HELD: begin
                    d = edge_t - press_t;
                    if (!c) begin
                        e[5] = 1'b1;
                        if (second || d > LD - 1) phase = PH_IDLE;
                        else begin phase = PH_GAP; rel_t = edge_t; end
                    end else if (d == LD - 1) begin
                        e[2] = 1'b1;
                    end else if (d > LD - 1 && (d - (LD - 1)) % RP == 0) begin
                        e[1] = 1'b1;
                    end
                end
                default: begin
                    if (c && !m_prev) begin
                        e[6] = 1'b1; e[3] = 1'b1;
                        phase = PH_HELD; press_t = edge_t; second = 1'b1;
                    end else if (edge_t - rel_t == DW) begin
                        e[4] = 1'b1;
                        phase = PH_IDLE;
                    end
                end
            endcase
        end
        e[0] = (phase == PH_HELD);
        m_prev  = c;
        edge_t  = edge_t + 1;
        exp_out = e;
    endtask

    // Drives one sample away from the active edge, advances the model, samples after the edge.
    task automatic step(input logic c, input logic r);
        @(negedge clock);
        clean = c;
        reset = r;
        @(posedge clock);
        model_edge(c, r);
        #1;
    endtask

    task automatic settle(input string name);
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b0);
            n_checks++;
            if (outs !== exp_out) begin
                n_fail++;
                $display("FAIL %s_settle k=%0d got=%b want=%b", name, k, outs, exp_out);
            end
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1);
            n_checks++;
            if (outs !== 7'b0) begin
                n_fail++;
                $display("FAIL reset_outputs k=%0d got=%b want=%b", k, outs, 7'b0);
            end
        end
        settle("reset");
    endtask

    task automatic test_single_click();
        logic [6:0] want;
        settle("single");
        for (int k = 0; k < 14; k++) begin
            step(k <= 2, 1'b0);
            n_checks++;
            if (outs !== exp_out) begin
                n_fail++;
                $display("FAIL single_click_model k=%0d got=%b want=%b", k, outs, exp_out);
            end
            case (k)
                0: want = 7'b1000001;
                1, 2: want = 7'b0000001;
                3: want = 7'b0100000;
                9: want = 7'b0010000;
                default: want = 7'b0;
            endcase
            n_checks++;
            if (outs !== want) begin
                n_fail++;
                $display("FAIL single_click k=%0d got=%b want=%b", k, outs, want);
            end
        end
    endtask

    task automatic test_double_click();
        logic [6:0] want;
        settle("double");
        for (int k = 0; k < 18; k++) begin
            step((k <= 2) || (k == 6) || (k == 7), 1'b0);
            n_checks++;
            if (outs !== exp_out) begin
                n_fail++;
                $display("FAIL double_click_model k=%0d got=%b want=%b", k, outs, exp_out);
            end
            case (k)
                0: want = 7'b1000001;
                1, 2, 7: want = 7'b0000001;
                3, 8: want = 7'b0100000;
                6: want = 7'b1001001;
                default: want = 7'b0;
            endcase
            n_checks++;
            if (outs !== want) begin
                n_fail++;
                $display("FAIL double_click k=%0d got=%b want=%b", k, outs, want);
            end
        end
    endtask

    task automatic test_window_boundary();
        logic [6:0] want;
        settle("window_in");
        for (int k = 0; k < 20; k++) begin
            step((k <= 2) || (k == 9) || (k == 10), 1'b0);
            n_checks++;
            if (outs !== exp_out) begin
                n_fail++;
                $display("FAIL window_in_model k=%0d got=%b want=%b", k, outs, exp_out);
            end
            if (k == 9 || k == 11) begin
                want = (k == 9) ? 7'b1001001 : 7'b0100000;
                n_checks++;
                if (outs !== want) begin
                    n_fail++;
                    $display("FAIL window_in k=%0d got=%b want=%b", k, outs, want);
                end
            end
        end
        settle("window_out");
        for (int k = 0; k < 22; k++) begin
            step((k <= 2) || (k == 10) || (k == 11), 1'b0);
            n_checks++;
            if (outs !== exp_out) begin
                n_fail++;
                $display("FAIL window_out_model k=%0d got=%b want=%b", k, outs, exp_out);
            end
            if (k == 9 || k == 10 || k == 12 || k == 18) begin
                case (k)
                    9: want = 7'b0010000;
                    10: want = 7'b1000001;
                    12: want = 7'b0100000;
                    default: want = 7'b0010000;
                endcase
                n_checks++;
                if (outs !== want) begin
                    n_fail++;
                    $display("FAIL window_out k=%0d got=%b want=%b", k, outs, want);
                end
            end
        end
    endtask

    task automatic test_long_repeat();
        logic [6:0] want;
        settle("long");
        for (int k = 0; k < 28; k++) begin
            step(k <= 20, 1'b0);
            n_checks++;
            if (outs !== exp_out) begin
                n_fail++;
                $display("FAIL long_repeat_model k=%0d got=%b want=%b", k, outs, exp_out);
            end
            case (k)
                0: want = 7'b1000001;
                9: want = 7'b0000101;
                13, 17: want = 7'b0000011;
                21: want = 7'b0100000;
                default: want = (k <= 20) ? 7'b0000001 : 7'b0;
            endcase
            n_checks++;
            if (outs !== want) begin
                n_fail++;
                $display("FAIL long_repeat k=%0d got=%b want=%b", k, outs, want);
            end
        end
    endtask

    task automatic test_reset_interactions();
        settle("reset_held");
        for (int k = 0; k < 14; k++) begin
            step(k <= 5, k <= 2);
            n_checks++;
            if (outs !== 7'b0) begin
                n_fail++;
                $display("FAIL reset_held k=%0d got=%b want=%b", k, outs, 7'b0);
            end
        end
        settle("reset_gap");
        for (int k = 0; k < 16; k++) begin
            step(k <= 2, k == 5);
            n_checks++;
            if (outs !== exp_out) begin
                n_fail++;
                $display("FAIL reset_gap_model k=%0d got=%b want=%b", k, outs, exp_out);
            end
            if (k >= 5) begin
                n_checks++;
                if (outs !== 7'b0) begin
                    n_fail++;
                    $display("FAIL reset_gap k=%0d got=%b want=%b", k, outs, 7'b0);
                end
            end
        end
    endtask

    task automatic test_second_long();
        logic [6:0] want;
        settle("second_long");
        for (int k = 0; k < 32; k++) begin
            step((k <= 2) || (k >= 6 && k <= 21), 1'b0);
            n_checks++;
            if (outs !== exp_out) begin
                n_fail++;
                $display("FAIL second_long_model k=%0d got=%b want=%b", k, outs, exp_out);
            end
            if (k == 6 || k == 15 || k == 19 || k == 22 || k == 29) begin
                case (k)
                    6: want = 7'b1001001;
                    15: want = 7'b0000101;
                    19: want = 7'b0000011;
                    22: want = 7'b0100000;
                    default: want = 7'b0;
                endcase
                n_checks++;
                if (outs !== want) begin
                    n_fail++;
                    $display("FAIL second_long k=%0d got=%b want=%b", k, outs, want);
                end
            end
        end
    endtask

    task automatic test_random();
        logic level;
        int   run_left;
        level    = 1'b0;
        run_left = 3;
        settle("random");
        for (int k = 0; k < 1500; k++) begin
            if (run_left == 0) begin
                level    = ~level;
                run_left = $urandom_range(1, (level ? 16 : 9));
            end
            run_left--;
            step(level, $urandom_range(0, 99) == 0);
            n_checks++;
            if (outs !== exp_out) begin
                n_fail++;
                $display("FAIL random_model k=%0d got=%b want=%b", k, outs, exp_out);
            end
            n_checks++;
            if ((double_pulse && !press_pulse) ||
                (int'(click_pulse) + int'(long_pulse) + int'(repeat_pulse) > 1)) begin
                n_fail++;
                $display("FAIL random_exclusion k=%0d got=%b want=%s", k, outs, "exclusive");
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        clean = 1'b0;
        test_reset();
        test_single_click();
        test_double_click();
        test_window_boundary();
        test_long_repeat();
        test_reset_interactions();
        test_second_long();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
